// File: rtl/dds_pkg.sv
// Shared constants and types for the multi-channel DDS phase accumulator.
// Config addresses, CTRL bit positions and the pipeline beat flags.
package dds_pkg;

  localparam logic [1:0] CFG_INC    = 2'd0;
  localparam logic [1:0] CFG_OFFSET = 2'd1;
  localparam logic [1:0] CFG_DELTA  = 2'd2;
  localparam logic [1:0] CFG_CTRL   = 2'd3;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_SWEEP = 1;
  localparam int CTRL_CLR   = 2;

  // Width-independent part of an output beat; channel and phase travel beside it.
  typedef struct packed {
    logic valid;
    logic carry;
  } beat_ctl_t;

endpackage

// File: rtl/dds_ch_regfile.sv
// Per-channel register storage: inc/offset/delta/ctrl/acc, config write decode,
// one slot read port and a write-back port addressed by the same slot.
module dds_ch_regfile
  import dds_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int INC_W  = 32,
  parameter int ACC_W  = 32,
  localparam int CH_W  = $clog2(NUM_CH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sync_i,
  input  logic              cfg_we_i,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [1:0]        cfg_addr_i,
  input  logic [ACC_W-1:0]  cfg_data_i,
  input  logic [CH_W-1:0]   rd_ch_i,
  output logic [INC_W-1:0]  rd_inc_o,
  output logic [ACC_W-1:0]  rd_offset_o,
  output logic [INC_W-1:0]  rd_delta_o,
  output logic              rd_en_o,
  output logic              rd_sweep_o,
  output logic [ACC_W-1:0]  rd_acc_o,
  input  logic              acc_we_i,
  input  logic [ACC_W-1:0]  acc_wdata_i,
  input  logic              inc_we_i,
  input  logic [INC_W-1:0]  inc_wdata_i
);

  logic [INC_W-1:0] inc_arr    [NUM_CH];
  logic [ACC_W-1:0] offset_arr [NUM_CH];
  logic [INC_W-1:0] delta_arr  [NUM_CH];
  logic [ACC_W-1:0] acc_arr    [NUM_CH];
  logic [NUM_CH-1:0] en_vec;
  logic [NUM_CH-1:0] sweep_vec;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [INC_W-1:0] inc_reg;
    logic [ACC_W-1:0] offset_reg;
    logic [INC_W-1:0] delta_reg;
    logic [ACC_W-1:0] acc_reg;
    logic             en_reg;
    logic             sweep_reg;
    logic             cfg_hit;
    logic             slot_hit;

    assign cfg_hit  = cfg_we_i && (cfg_ch_i == CH_W'(gi));
    assign slot_hit = (rd_ch_i == CH_W'(gi));

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        inc_reg    <= '0;
        offset_reg <= '0;
        delta_reg  <= '0;
        acc_reg    <= '0;
        en_reg     <= 1'b0;
        sweep_reg  <= 1'b0;
      end else begin
        // A host write beats the sweep write-back; the slot already used the old inc.
        if (cfg_hit && cfg_addr_i == CFG_INC)
          inc_reg <= cfg_data_i[INC_W-1:0];
        else if (inc_we_i && slot_hit)
          inc_reg <= inc_wdata_i;
        if (cfg_hit && cfg_addr_i == CFG_OFFSET)
          offset_reg <= cfg_data_i;
        if (cfg_hit && cfg_addr_i == CFG_DELTA)
          delta_reg <= cfg_data_i[INC_W-1:0];
        if (cfg_hit && cfg_addr_i == CFG_CTRL) begin
          en_reg    <= cfg_data_i[CTRL_EN];
          sweep_reg <= cfg_data_i[CTRL_SWEEP];
        end
        // Clear is a one-shot action on the accumulator, never stored.
        if (sync_i || (cfg_hit && cfg_addr_i == CFG_CTRL && cfg_data_i[CTRL_CLR]))
          acc_reg <= '0;
        else if (acc_we_i && slot_hit)
          acc_reg <= acc_wdata_i;
      end
    end

    assign inc_arr[gi]    = inc_reg;
    assign offset_arr[gi] = offset_reg;
    assign delta_arr[gi]  = delta_reg;
    assign acc_arr[gi]    = acc_reg;
    assign en_vec[gi]     = en_reg;
    assign sweep_vec[gi]  = sweep_reg;
  end

  assign rd_inc_o    = inc_arr[rd_ch_i];
  assign rd_offset_o = offset_arr[rd_ch_i];
  assign rd_delta_o  = delta_arr[rd_ch_i];
  assign rd_acc_o    = acc_arr[rd_ch_i];
  assign rd_en_o     = en_vec[rd_ch_i];
  assign rd_sweep_o  = sweep_vec[rd_ch_i];

endmodule

// File: rtl/dds_phase_acc_mc.sv
// Time-multiplexed phase accumulator: one adder pipeline serves NUM_CH channels
// round-robin and emits a (channel, phase, carry) stream two cycles after each slot.
module dds_phase_acc_mc
  import dds_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int PHASE_INC_WIDTH = 32,
  parameter int PHASE_ACC_WIDTH = 32,
  parameter int PHASE_OUT_WIDTH = 16,
  localparam int CH_W           = $clog2(NUM_CH)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       run_i,
  input  logic                       phase_sync_i,
  input  logic                       cfg_we_i,
  input  logic [CH_W-1:0]            cfg_ch_i,
  input  logic [1:0]                 cfg_addr_i,
  input  logic [PHASE_ACC_WIDTH-1:0] cfg_data_i,
  output logic                       out_valid_o,
  output logic [CH_W-1:0]            out_ch_o,
  output logic [PHASE_OUT_WIDTH-1:0] phase_o,
  output logic                       carry_o
);

  localparam int INC_W = PHASE_INC_WIDTH;
  localparam int ACC_W = PHASE_ACC_WIDTH;
  localparam int OUT_W = PHASE_OUT_WIDTH;

  logic [CH_W-1:0]  slot_reg, slot_next;
  logic [INC_W-1:0] rd_inc, rd_delta, inc_swept;
  logic [ACC_W-1:0] rd_acc, rd_offset;
  logic             rd_en, rd_sweep;
  logic [ACC_W:0]   acc_sum;
  logic             acc_we, inc_we;

  beat_ctl_t        s1_ctl_reg;
  logic [CH_W-1:0]  s1_ch_reg;
  logic [ACC_W-1:0] s1_acc_reg, s1_offset_reg;
  beat_ctl_t        out_ctl_reg;
  logic [CH_W-1:0]  out_ch_reg;
  logic [OUT_W-1:0] phase_reg;

  dds_ch_regfile #(
    .NUM_CH (NUM_CH),
    .INC_W  (INC_W),
    .ACC_W  (ACC_W)
  ) u_regfile (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .sync_i      (phase_sync_i),
    .cfg_we_i    (cfg_we_i),
    .cfg_ch_i    (cfg_ch_i),
    .cfg_addr_i  (cfg_addr_i),
    .cfg_data_i  (cfg_data_i),
    .rd_ch_i     (slot_reg),
    .rd_inc_o    (rd_inc),
    .rd_offset_o (rd_offset),
    .rd_delta_o  (rd_delta),
    .rd_en_o     (rd_en),
    .rd_sweep_o  (rd_sweep),
    .rd_acc_o    (rd_acc),
    .acc_we_i    (acc_we),
    .acc_wdata_i (acc_sum[ACC_W-1:0]),
    .inc_we_i    (inc_we),
    .inc_wdata_i (inc_swept)
  );

  assign acc_sum   = {1'b0, rd_acc} + (ACC_W+1)'(rd_inc);
  assign inc_swept = rd_inc + rd_delta;
  assign acc_we    = run_i && !phase_sync_i && rd_en;
  assign inc_we    = acc_we && rd_sweep;

  always_comb begin
    slot_next = slot_reg;
    if (phase_sync_i)
      slot_next = '0;
    else if (run_i)
      slot_next = (slot_reg == CH_W'(NUM_CH - 1)) ? '0 : slot_reg + CH_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      slot_reg      <= '0;
      s1_ctl_reg    <= '0;
      s1_ch_reg     <= '0;
      s1_acc_reg    <= '0;
      s1_offset_reg <= '0;
      out_ctl_reg   <= '0;
      out_ch_reg    <= '0;
      phase_reg     <= '0;
    end else begin
      slot_reg         <= slot_next;
      s1_ctl_reg.valid <= acc_we;
      // Offset is captured with the slot so a later write cannot tear the beat.
      if (acc_we) begin
        s1_ctl_reg.carry <= acc_sum[ACC_W];
        s1_ch_reg        <= slot_reg;
        s1_acc_reg       <= acc_sum[ACC_W-1:0];
        s1_offset_reg    <= rd_offset;
      end
      out_ctl_reg.valid <= s1_ctl_reg.valid;
      if (s1_ctl_reg.valid) begin
        out_ctl_reg.carry <= s1_ctl_reg.carry;
        out_ch_reg        <= s1_ch_reg;
        phase_reg         <= OUT_W'((s1_acc_reg + s1_offset_reg) >> (ACC_W - OUT_W));
      end
    end
  end

  assign out_valid_o = out_ctl_reg.valid;
  assign carry_o     = out_ctl_reg.carry;
  assign out_ch_o    = out_ch_reg;
  assign phase_o     = phase_reg;

endmodule

// File: tb/tb_dds_phase_acc_mc.sv
// Directed bench for dds_phase_acc_mc with NUM_CH=4, 16-bit acc/inc, 8-bit phase.
// Every output cycle is compared against hand-computed beats.
module tb_dds_phase_acc_mc;
  import dds_pkg::*;

  logic        clk_i;
  logic        rst_ni;
  logic        run_i;
  logic        phase_sync_i;
  logic        cfg_we_i;
  logic [1:0]  cfg_ch_i;
  logic [1:0]  cfg_addr_i;
  logic [15:0] cfg_data_i;
  logic        out_valid_o;
  logic [1:0]  out_ch_o;
  logic [7:0]  phase_o;
  logic        carry_o;

  int n_checks = 0;
  int n_errors = 0;

  // Round-robin run with all four channels enabled: expected phase/carry per visit.
  int exp_ph [4][6] = '{
    '{'h10, 'h20, 'h30, 'h40, 'h50, 'h60},
    '{'h40, 'h80, 'hC0, 'h00, 'h40, 'h80},
    '{'h00, 'h01, 'h02, 'h03, 'h04, 'h05},
    '{'h01, 'h01, 'h01, 'h01, 'h00, 'hFE}
  };
  int exp_cy [4][6] = '{
    '{0, 0, 0, 0, 0, 0},
    '{0, 0, 0, 1, 0, 0},
    '{0, 0, 0, 0, 0, 0},
    '{0, 0, 0, 1, 1, 0}
  };

  dds_phase_acc_mc #(
    .NUM_CH          (4),
    .PHASE_INC_WIDTH (16),
    .PHASE_ACC_WIDTH (16),
    .PHASE_OUT_WIDTH (8)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .run_i        (run_i),
    .phase_sync_i (phase_sync_i),
    .cfg_we_i     (cfg_we_i),
    .cfg_ch_i     (cfg_ch_i),
    .cfg_addr_i   (cfg_addr_i),
    .cfg_data_i   (cfg_data_i),
    .out_valid_o  (out_valid_o),
    .out_ch_o     (out_ch_o),
    .phase_o      (phase_o),
    .carry_o      (carry_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One clock, then compare the output beat (fields only when a beat is expected).
  task automatic step(input string tag, input logic ev, input int ech, input int eph,
                      input logic ecy);
    tick();
    check({tag, ".valid"}, 32'(out_valid_o), 32'(ev));
    if (ev) begin
      check({tag, ".ch"}, 32'(out_ch_o), 32'(ech));
      check({tag, ".phase"}, 32'(phase_o), 32'(eph));
      check({tag, ".carry"}, 32'(carry_o), 32'(ecy));
      $display("beat %s: ch=%0d phase=0x%02h carry=%0b", tag, out_ch_o, phase_o, carry_o);
    end
  endtask

  task automatic cfg_wr(input int ch, input logic [1:0] addr, input logic [15:0] data,
                        input logic sync);
    cfg_we_i     = 1'b1;
    cfg_ch_i     = 2'(ch);
    cfg_addr_i   = addr;
    cfg_data_i   = data;
    phase_sync_i = sync;
    tick();
    cfg_we_i     = 1'b0;
    phase_sync_i = 1'b0;
  endtask

  initial begin
    rst_ni       = 1'b0;
    run_i        = 1'b0;
    phase_sync_i = 1'b0;
    cfg_we_i     = 1'b0;
    cfg_ch_i     = '0;
    cfg_addr_i   = '0;
    cfg_data_i   = '0;
    repeat (3) tick();
    check("reset.valid", 32'(out_valid_o), 32'd0);
    check("reset.ch", 32'(out_ch_o), 32'd0);
    check("reset.phase", 32'(phase_o), 32'd0);
    check("reset.carry", 32'(carry_o), 32'd0);
    rst_ni = 1'b1;

    // Basic round-robin: only ch0 enabled, beat every 4 cycles, 2-cycle latency.
    cfg_wr(0, CFG_INC, 16'h1000, 1'b0);
    cfg_wr(0, CFG_CTRL, 16'h0001, 1'b0);
    run_i = 1'b1;
    step("rr1_slot", 1'b0, 0, 0, 1'b0);
    step("rr1_b1", 1'b1, 0, 'h10, 1'b0);
    for (int i = 0; i < 3; i++) step("rr1_idle_a", 1'b0, 0, 0, 1'b0);
    step("rr1_b2", 1'b1, 0, 'h20, 1'b0);
    for (int i = 0; i < 3; i++) step("rr1_idle_b", 1'b0, 0, 0, 1'b0);
    run_i = 1'b0;
    step("rr1_b3", 1'b1, 0, 'h30, 1'b0);
    step("drain_a", 1'b0, 0, 0, 1'b0);
    step("drain_b", 1'b0, 0, 0, 1'b0);
    // Restart resumes at slot 1; ch0 continues from the frozen accumulator.
    run_i = 1'b1;
    for (int i = 0; i < 4; i++) step("resume_idle", 1'b0, 0, 0, 1'b0);
    run_i = 1'b0;
    step("resume_b4", 1'b1, 0, 'h40, 1'b0);
    step("resume_drain", 1'b0, 0, 0, 1'b0);

    // Wrap/carry, offset and sweep channels; sync lands together with the last write.
    cfg_wr(1, CFG_INC, 16'h4000, 1'b0);
    cfg_wr(1, CFG_CTRL, 16'h0001, 1'b0);
    cfg_wr(2, CFG_INC, 16'h0100, 1'b0);
    cfg_wr(2, CFG_OFFSET, 16'hFF00, 1'b0);
    cfg_wr(2, CFG_CTRL, 16'h0001, 1'b0);
    cfg_wr(3, CFG_INC, 16'h0100, 1'b0);
    cfg_wr(3, CFG_DELTA, 16'hFF80, 1'b0);
    cfg_wr(3, CFG_CTRL, 16'h0003, 1'b1);
    run_i = 1'b1;
    for (int e = 1; e <= 25; e++) begin
      if (e == 1) begin
        step("all_first", 1'b0, 0, 0, 1'b0);
      end else begin
        int s;
        int n;
        s = (e - 2) % 4;
        n = (e - 2) / 4;
        step($sformatf("all_ch%0d_v%0d", s, n + 1), 1'b1, s, exp_ph[s][n], exp_cy[s][n] != 0);
      end
      if (e == 24) run_i = 1'b0;
    end
    step("all_drain", 1'b0, 0, 0, 1'b0);

    // Sync mid-run: beat already in flight survives, then ch0 restarts from zero.
    run_i = 1'b1;
    step("sync_pre0", 1'b0, 0, 0, 1'b0);
    step("sync_pre1", 1'b1, 0, 'h70, 1'b0);
    phase_sync_i = 1'b1;
    step("sync_inflight", 1'b1, 1, 'hC0, 1'b0);
    phase_sync_i = 1'b0;
    cfg_we_i     = 1'b1;
    cfg_ch_i     = 2'd0;
    cfg_addr_i   = CFG_INC;
    cfg_data_i   = 16'h2000;
    step("sync_bubble", 1'b0, 0, 0, 1'b0);
    cfg_we_i = 1'b0;
    step("sync_ch0_oldinc", 1'b1, 0, 'h10, 1'b0);
    step("sync_ch1", 1'b1, 1, 'h40, 1'b0);
    step("sync_ch2", 1'b1, 2, 'h00, 1'b0);
    step("sync_ch3", 1'b1, 3, 'hFE, 1'b0);
    run_i = 1'b0;
    step("slot_wr_newinc", 1'b1, 0, 'h30, 1'b0);
    step("sync_drain", 1'b0, 0, 0, 1'b0);

    // Reset with beats in flight.
    run_i = 1'b1;
    step("rst_pre0", 1'b0, 0, 0, 1'b0);
    step("rst_pre1", 1'b1, 1, 'h80, 1'b0);
    rst_ni = 1'b0;
    tick();
    check("midrst.valid", 32'(out_valid_o), 32'd0);
    check("midrst.ch", 32'(out_ch_o), 32'd0);
    check("midrst.phase", 32'(phase_o), 32'd0);
    check("midrst.carry", 32'(carry_o), 32'd0);
    run_i = 1'b0;
    tick();
    rst_ni = 1'b1;

    // After reset: inc/offset/acc are zero, only re-enabled channels emit.
    cfg_wr(0, CFG_CTRL, 16'h0001, 1'b0);
    cfg_wr(2, CFG_CTRL, 16'h0001, 1'b0);
    run_i = 1'b1;
    step("post_slot", 1'b0, 0, 0, 1'b0);
    step("post_ch0", 1'b1, 0, 'h00, 1'b0);
    step("post_ch1_off", 1'b0, 0, 0, 1'b0);
    step("post_ch2", 1'b1, 2, 'h00, 1'b0);
    run_i = 1'b0;
    step("post_drain", 1'b0, 0, 0, 1'b0);

    // CTRL clear zeroes ch0 accumulator while keeping it enabled.
    cfg_wr(0, CFG_INC, 16'h1000, 1'b0);
    run_i = 1'b1;
    step("clr_pre0", 1'b0, 0, 0, 1'b0);
    step("clr_pre_ch0", 1'b1, 0, 'h10, 1'b0);
    step("clr_pre_idle", 1'b0, 0, 0, 1'b0);
    step("clr_pre_ch2", 1'b1, 2, 'h00, 1'b0);
    run_i = 1'b0;
    step("clr_pre_drain", 1'b0, 0, 0, 1'b0);
    cfg_wr(0, CFG_CTRL, 16'h0005, 1'b0);
    run_i = 1'b1;
    step("clr_slot", 1'b0, 0, 0, 1'b0);
    run_i = 1'b0;
    step("clr_ch0", 1'b1, 0, 'h10, 1'b0);
    step("clr_drain", 1'b0, 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
